// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolve unit and its BTB update queue.
package branch_pkg;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] BTB_INVALID = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } btb_update_t;

  typedef enum logic {
    BR_IDLE,
    BR_FLUSH
  } br_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_btb_update_fifo.sv
// Synchronous FIFO of BTB write-backs; head is read straight from registered storage.
module btb_update_fifo
  import branch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  btb_update_t push_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output btb_update_t head_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  btb_update_t mem_q [FIFO_DEPTH];
  btb_update_t mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push to a full queue still lands.
    do_push = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
    head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: mispredict detection, registered redirect, flush FSM,
// BTB write-back generation and saturating performance counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int N            = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_is_jump_i,
  input  logic        ex_taken_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_hit_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic        update_btb_address_o,
  input  logic        btb_ready_i,
  output logic [31:0] pc_btb_o,
  output logic [31:0] btb_address_value_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o,
  output logic [31:0] drop_count_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e   state_q, state_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  logic        resolve, taken, mispredict, push_req, pop, fifo_full, fifo_empty;
  logic [31:0] seq_pc, actual_pc, predicted_pc;
  btb_update_t push_data, head;

  always_comb begin
    resolve      = ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && (state_q == BR_IDLE);
    taken        = ex_is_jump_i || ex_taken_i;
    seq_pc       = pc_ex_i + PC_INC;
    actual_pc    = taken ? ex_target_i : seq_pc;
    predicted_pc = ex_pred_hit_i ? ex_pred_target_i : seq_pc;
    mispredict   = resolve && (actual_pc != predicted_pc);
    push_req     = resolve && ((taken && (!ex_pred_hit_i || (ex_pred_target_i != ex_target_i)))
                               || (!taken && ex_pred_hit_i));
    push_data.pc     = pc_ex_i;
    push_data.target = taken ? ex_target_i : BTB_INVALID;
    pop = !fifo_empty && btb_ready_i;

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q == BR_IDLE) begin
      if (mispredict) begin
        state_d     = BR_FLUSH;
        flush_cnt_d = CW'(FLUSH_CYCLES - 1);
      end
    end else if (flush_cnt_q == '0) begin
      state_d = BR_IDLE;
    end else begin
      flush_cnt_d = flush_cnt_q - CW'(1);
    end
    flush_d = (state_d == BR_FLUSH);

    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? actual_pc : redirect_pc_q;

    branch_count_d     = resolve    ? sat_inc(branch_count_q)     : branch_count_q;
    mispredict_count_d = mispredict ? sat_inc(mispredict_count_q) : mispredict_count_q;
    drop_count_d       = (push_req && fifo_full && !pop) ? sat_inc(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q            <= BR_IDLE;
      flush_cnt_q        <= '0;
      flush_q            <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      drop_count_q       <= '0;
    end else begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      flush_q            <= flush_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      drop_count_q       <= drop_count_d;
    end
  end

  btb_update_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_req),
    .push_data_i (push_data),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign redirect_valid_o     = redirect_valid_q;
  assign redirect_pc_o        = redirect_pc_q;
  assign flush_o              = flush_q;
  assign update_btb_address_o = !fifo_empty;
  assign pc_btb_o             = head.pc;
  assign btb_address_value_o  = head.target;
  assign branch_count_o       = branch_count_q;
  assign mispredict_count_o   = mispredict_count_q;
  assign drop_count_o         = drop_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

  localparam int DEPTH  = 4;
  localparam int FLUSHC = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i;
  logic [31:0] pc_ex_i, ex_target_i, ex_pred_target_i;
  logic        ex_pred_hit_i;
  logic        redirect_valid_o, flush_o, update_btb_address_o, btb_ready_i;
  logic [31:0] redirect_pc_o, pc_btb_o, btb_address_value_o;
  logic [31:0] branch_count_o, mispredict_count_o, drop_count_o;

  branch_resolve_unit #(.N(10), .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSHC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .ex_is_jump_i(ex_is_jump_i),
    .ex_taken_i(ex_taken_i), .pc_ex_i(pc_ex_i), .ex_target_i(ex_target_i),
    .ex_pred_hit_i(ex_pred_hit_i), .ex_pred_target_i(ex_pred_target_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .update_btb_address_o(update_btb_address_o), .btb_ready_i(btb_ready_i),
    .pc_btb_o(pc_btb_o), .btb_address_value_o(btb_address_value_o),
    .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o),
    .drop_count_o(drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } upd_t;

  upd_t        m_q[$];
  int          m_flush_left;
  logic        m_rv;
  logic [31:0] m_rpc, m_bc, m_mc, m_dc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Next-state of the model from the inputs presented this cycle.
  task automatic model_step();
    logic        pop, resolve, tk, mis, push;
    logic [31:0] actual, predicted;
    bit          was_full;
    if (!rst_i) begin
      m_q.delete();
      m_flush_left = 0;
      m_rv = 0; m_rpc = 0; m_bc = 0; m_mc = 0; m_dc = 0;
      return;
    end
    pop       = (m_q.size() != 0) && btb_ready_i;
    resolve   = ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && (m_flush_left == 0);
    tk        = ex_is_jump_i || ex_taken_i;
    actual    = tk ? ex_target_i : pc_ex_i + 4;
    predicted = ex_pred_hit_i ? ex_pred_target_i : pc_ex_i + 4;
    mis       = resolve && (actual != predicted);
    push      = resolve && ((tk && (!ex_pred_hit_i || ex_pred_target_i != ex_target_i))
                            || (!tk && ex_pred_hit_i));
    m_rv = mis;
    if (mis) m_rpc = actual;
    if (m_flush_left > 0) m_flush_left--;
    if (mis) m_flush_left = FLUSHC;
    was_full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!was_full || pop) m_q.push_back('{pc: pc_ex_i, tgt: tk ? ex_target_i : 32'h0});
      else m_dc = bump(m_dc);
    end
    if (resolve) m_bc = bump(m_bc);
    if (mis) m_mc = bump(m_mc);
  endtask

  task automatic compare_all();
    chk("redirect_valid", redirect_valid_o, m_rv);
    chk("redirect_pc", redirect_pc_o, m_rpc);
    chk("flush", flush_o, m_flush_left > 0);
    chk("upd_valid", update_btb_address_o, m_q.size() != 0);
    chk("btb_pc", pc_btb_o, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
    chk("btb_value", btb_address_value_o, (m_q.size() != 0) ? m_q[0].tgt : 32'h0);
    chk("branch_count", branch_count_o, m_bc);
    chk("mispredict_count", mispredict_count_o, m_mc);
    chk("drop_count", drop_count_o, m_dc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic hit, input logic [31:0] pred);
    ex_valid_i = v; ex_is_branch_i = br; ex_is_jump_i = jp; ex_taken_i = tk;
    pc_ex_i = pc; ex_target_i = tgt; ex_pred_hit_i = hit; ex_pred_target_i = pred;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    rst_i = 1'b0; btb_ready_i = 1'b0;
    idle();
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b1;

    // Correctly predicted taken branch.
    drive(1, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200);
    tick();
    chk("hit_no_redirect", redirect_valid_o, 1'b0);
    chk("hit_branch_count", branch_count_o, 32'd1);

    // Cold jump: redirect, two-cycle flush, install queued then popped.
    drive(1, 0, 1, 0, 32'h40, 32'h80, 0, 32'h0);
    tick();
    chk("cold_redirect_pc", redirect_pc_o, 32'h80);
    chk("cold_head_value", btb_address_value_o, 32'h80);
    idle(); btb_ready_i = 1'b1;
    tick();
    chk("cold_popped", update_btb_address_o, 1'b0);
    chk("cold_flush2", flush_o, 1'b1);
    tick();
    chk("cold_flush_done", flush_o, 1'b0);

    // Not-taken with stale hit: invalidate, then wrong-path branches in both flush cycles.
    btb_ready_i = 1'b0;
    drive(1, 1, 0, 0, 32'h10, 32'h30, 1, 32'h30);
    tick();
    chk("nt_redirect_pc", redirect_pc_o, 32'h14);
    chk("nt_invalidate", btb_address_value_o, 32'h0);
    drive(1, 1, 0, 1, 32'h300, 32'h400, 0, 32'h0);
    tick();
    tick();
    chk("wrong_path_bc", branch_count_o, 32'd3);
    idle();
    tick();

    // Fill the queue with cold jumps; the fifth is dropped.
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 32'h1000 + 32'(i) * 32'h100, 32'h2000 + 32'(i) * 32'h40, 0, 32'h0);
      tick();
      idle();
      tick();
      tick();
    end
    chk("full_drop", drop_count_o, 32'd1);
    // Full with a pop and a fall-through install: both accepted.
    btb_ready_i = 1'b1;
    drive(1, 1, 0, 1, 32'h500, 32'h504, 0, 32'h0);
    tick();
    chk("full_pushpop_drop", drop_count_o, 32'd1);
    chk("full_pushpop_no_redirect", redirect_valid_o, 1'b0);
    // Reset in the middle of a flush with entries queued.
    btb_ready_i = 1'b0;
    drive(1, 0, 1, 0, 32'h600, 32'h700, 0, 32'h0);
    tick();
    idle(); rst_i = 1'b0;
    tick();
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_upd_valid", update_btb_address_o, 1'b0);
    chk("rst_mispredict_count", mispredict_count_o, 32'd0);
    rst_i = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] pc, tgt, pred;
      int kind;
      rst_i = ($urandom_range(0, 149) != 0);
      btb_ready_i = ($urandom_range(0, 2) == 0);
      pc   = 32'($urandom_range(0, 1023)) << 2;
      tgt  = 32'($urandom_range(1, 1023)) << 2;
      case ($urandom_range(0, 2))
        0: pred = tgt;
        1: pred = pc + 4;
        default: pred = 32'($urandom_range(1, 1023)) << 2;
      endcase
      kind = $urandom_range(0, 2);
      drive($urandom_range(0, 3) != 0, kind == 0, kind == 1, $urandom_range(0, 1) == 1,
            pc, tgt, $urandom_range(0, 1) == 1, pred);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
